// File: rtl/fifoout_burst_sched.sv
// fifoout_burst_sched
// Write-side fetch scheduler for the 256-bit-in / 32-bit-out output FIFO.
// It issues fixed-length read bursts to the memory controller while the FIFO has
// room. It registers the returned beats into the FIFO and walks one frame of
// consecutive bursts.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no frame active, waiting for frame_start_i
// ST_ARB    | frame active, waiting for enable_i and enough FIFO headroom
// ST_REQ    | rd_req_o asserted, waiting for rd_ack_i
// ST_DATA   | counting returned beats of the outstanding burst
// ST_SETTLE | short wait so the FIFO water level catches up with writes
module fifoout_burst_sched #(
    parameter int                    WR_DEPTH_WIDTH = 8,
    parameter int                    WR_DATA_WIDTH  = 256,
    parameter int                    ADDR_WIDTH     = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    BURST_LEN      = 16,
    parameter int                    FRAME_BURSTS   = 480,
    parameter int                    MARGIN         = 4,
    parameter int                    SETTLE_CYC     = 2
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic                      enable_i,
    input  logic                      frame_start_i,
    output logic                      rd_req_o,
    output logic [ADDR_WIDTH-1:0]     rd_addr_o,
    output logic [15:0]               rd_len_o,
    input  logic                      rd_ack_i,
    input  logic                      rd_data_valid_i,
    input  logic [WR_DATA_WIDTH-1:0]  rd_data_i,
    output logic                      fifo_wr_en_o,
    output logic [WR_DATA_WIDTH-1:0]  fifo_wr_data_o,
    input  logic [WR_DEPTH_WIDTH:0]   fifo_wr_water_level_i,
    input  logic                      fifo_wr_full_i,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      overflow_err_o,
    output logic                      protocol_err_o
);

    localparam int IDX_W  = $clog2(FRAME_BURSTS) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int SC_W   = $clog2(SETTLE_CYC + 1) + 1;

    // Headroom threshold; a negative value means the FIFO can never take a burst.
    localparam int                        THRESH    = (2 ** WR_DEPTH_WIDTH) - BURST_LEN - MARGIN;
    localparam bit                        THRESH_OK = (THRESH >= 0);
    localparam logic [WR_DEPTH_WIDTH+1:0] THRESH_V  = (WR_DEPTH_WIDTH + 2)'(THRESH_OK ? THRESH : 0);

    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(FRAME_BURSTS - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [SC_W-1:0]       SETTLE_LOAD = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP  = ADDR_WIDTH'(BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ,
        ST_DATA,
        ST_SETTLE
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [SC_W-1:0]            settle_q, settle_d;
    logic                       restart_q, restart_d;
    logic                       done_q, done_d;
    logic                       wr_en_q, wr_en_d;
    logic [WR_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                       ovf_q, ovf_d;
    logic                       proto_q, proto_d;
    logic                       level_ok;

    assign level_ok = THRESH_OK && ({1'b0, fifo_wr_water_level_i} <= THRESH_V);

    // Next-state, burst/beat bookkeeping, write path and sticky error flags.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        settle_d  = settle_q;
        restart_d = restart_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start_i) begin
                    state_d = ST_ARB;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_ARB: begin
                if (frame_start_i) begin
                    idx_d  = '0;
                    addr_d = BASE_ADDR;
                end else if (enable_i && level_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A restart requested here waits until the pending burst has drained.
                if (frame_start_i) begin
                    restart_d = 1'b1;
                end
                if (rd_ack_i) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                if (frame_start_i) begin
                    restart_d = 1'b1;
                end
                if (rd_data_valid_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (restart_q || frame_start_i) begin
                            restart_d = 1'b0;
                            idx_d     = '0;
                            addr_d    = BASE_ADDR;
                            state_d   = ST_ARB;
                        end else if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            idx_d   = '0;
                            addr_d  = BASE_ADDR;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d    = idx_q + IDX_W'(1);
                            addr_d   = addr_q + BURST_STEP;
                            settle_d = SETTLE_LOAD;
                            state_d  = (SETTLE_CYC > 0) ? ST_SETTLE : ST_ARB;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (frame_start_i) begin
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    state_d = ST_ARB;
                end else if (settle_q == '0) begin
                    state_d = ST_ARB;
                end else begin
                    settle_d = settle_q - SC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Beats are only accepted while a burst is outstanding; anything else is flagged.
        wr_en_d   = rd_data_valid_i && (state_q == ST_DATA);
        wr_data_d = wr_en_d ? rd_data_i : wr_data_q;
        ovf_d     = ovf_q | (wr_en_q & fifo_wr_full_i);
        proto_d   = proto_q | (rd_data_valid_i & (state_q != ST_DATA));
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            addr_q    <= BASE_ADDR;
            beat_q    <= '0;
            settle_q  <= '0;
            restart_q <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            settle_q  <= settle_d;
            restart_q <= restart_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            proto_q   <= proto_d;
        end
    end

    assign rd_req_o       = (state_q == ST_REQ);
    assign rd_addr_o      = addr_q;
    assign rd_len_o       = 16'(BURST_LEN);
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_wr_data_o = wr_data_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign frame_done_o   = done_q;
    assign overflow_err_o = ovf_q;
    assign protocol_err_o = proto_q;

endmodule
